mem_arbiter_rr: RTL and testbench

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

---
 rtl/mem_arbiter_rr.sv | 123 ++++++++++++
 tb/tb_mem_arbiter_rr.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin read arbiter: N cache ports share one memory read channel,
// with a single request outstanding and a registered shared response word.
module mem_arbiter_rr #(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DWIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            req_valid,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr,
  output logic [N_PORTS-1:0]            req_ready,
  output logic [DWIDTH-1:0]             resp_data,
  output logic                          mem_rd_valid,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic                          mem_rd_ready,
  input  logic [DWIDTH-1:0]             mem_rd_data,
  input  logic                          mem_rd_data_valid,
  output logic                          busy
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GRANT,
    S_DELIVER
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]       resp_q, resp_d;

  logic [ADDR_WIDTH-1:0]   port_addr [N_PORTS];
  logic [IDX_W-1:0]        pick;
  logic                    pick_found;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
    assign port_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Search upward from the port after the last grant, wrapping once around.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      cand = int'(last_q) + k;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick       = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    addr_d    = addr_q;
    resp_d    = resp_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          idx_d   = pick;
          addr_d  = port_addr[pick];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_rd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_data_valid) begin
          resp_d  = mem_rd_data;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A port that withdrew meanwhile gets no pulse but still loses its turn.
        req_ready[idx_q] = req_valid[idx_q];
        last_d           = idx_q;
        state_d          = S_DELIVER;
      end
      S_DELIVER: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_PORTS - 1);
      addr_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
    end
  end

  assign mem_rd_valid = (state_q == S_ISSUE);
  assign mem_rd_addr  = addr_q;
  assign resp_data    = resp_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Randomized scoreboard bench for mem_arbiter_rr: a reference arbiter picks the
// expected port, a memory model answers reads, a monitor checks each transaction.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NTX = 300;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   resp_data;
  logic            mem_rd_valid;
  logic [AW-1:0]   mem_rd_addr;
  logic            mem_rd_ready = 1'b0;
  logic [DW-1:0]   mem_rd_data = '0;
  logic            mem_rd_data_valid = 1'b0;
  logic            busy;

  mem_arbiter_rr #(.N_PORTS(N), .ADDR_WIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_data(resp_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            wd;
  } exp_t;

  exp_t exp_q[$];
  int   mem_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stall = 1'b0;
  int   last_port = N - 1;

  function automatic logic [DW-1:0] memfunc(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = DW'(a * 16'h9E37);
    return t ^ 16'hBEEF;
  endfunction

  function automatic int model_pick(input int last, input logic [N-1:0] pat);
    for (int k = 1; k <= N; k++) begin
      int idx;
      logic [N-1:0] m;
      idx = (last + k) % N;
      m = N'(1) << idx;
      if ((pat & m) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_mem_rd_valid"}, 64'(mem_rd_valid), 64'(0));
    check({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 64'(0));
    check({tag, "_resp_data"}, 64'(resp_data), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic do_txn(input logic [N-1:0] pat, input logic [N*AW-1:0] addrs, input bit wd);
    int            p;
    exp_t          e;
    logic [N-1:0]  mask;
    logic [N-1:0]  v;
    logic [N*AW-1:0] scr;
    if (pat == '0) begin
      req_valid = '0;
      req_addr  = addrs;
      repeat (3) begin
        @(negedge clk);
        check("idle_no_req", 64'(busy), 64'(0));
      end
      return;
    end
    p = model_pick(last_port, pat);
    e.port = p;
    e.addr = addrs[p*AW +: AW];
    e.data = memfunc(e.addr);
    e.wd   = wd;
    exp_q.push_back(e);
    last_port = p;
    req_valid = pat;
    req_addr  = addrs;
    @(negedge clk);
    check("arb_started", 64'(busy), 64'(1));
    check("issue_valid", 64'(mem_rd_valid), 64'(1));
    check($sformatf("issue_addr_p%0d", p), 64'(mem_rd_addr), 64'(e.addr));
    // Disturb everything except the granted port's request line.
    scr  = {$urandom(), $urandom()};
    v    = N'($urandom());
    mask = N'(1) << p;
    req_addr  = scr;
    req_valid = wd ? (v & ~mask) : (v | mask);
    wait_idle();
  endtask

  // Memory model: random accept stall and data latency, stray data pulses when idle.
  initial begin
    int rw_cnt, rw_total, rw_used, lat, ghost;
    bit outstanding;
    logic [AW-1:0] acc;
    rw_cnt = 0; rw_total = 0; rw_used = 0; lat = 0; ghost = 0;
    outstanding = 1'b0; acc = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rd_data_valid = 1'b0;
      if (rst) begin
        mem_rd_ready = 1'b0;
        outstanding  = 1'b0;
        ghost        = 2;
      end else begin
        if (mem_rd_ready) begin
          mem_rd_ready = 1'b0;
          outstanding  = 1'b1;
          lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
          mem_q.push_back(rw_used + lat);
        end
        if (ghost > 0) begin
          ghost--;
          if (ghost == 0) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data       = 16'h1234;
          end
        end else if (outstanding) begin
          if (!stall) begin
            if (lat == 0) begin
              mem_rd_data_valid = 1'b1;
              mem_rd_data       = memfunc(acc);
              outstanding       = 1'b0;
            end else begin
              lat--;
            end
          end
        end else if (mem_rd_valid) begin
          if (rw_cnt == 0) begin
            mem_rd_ready = 1'b1;
            acc          = mem_rd_addr;
            rw_used      = rw_total;
            rw_total     = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            rw_cnt       = rw_total;
          end else begin
            rw_cnt--;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          mem_rd_data_valid = 1'b1;
          mem_rd_data       = DW'($urandom());
        end
      end
    end
  end

  // Monitor: gathers grant pulses and memory activity, scores at end of each transaction.
  initial begin
    int            pulses, bcyc;
    logic [N-1:0]  pvec;
    logic [DW-1:0] pdata;
    logic [AW-1:0] prev_addr, acc_addr;
    bit            chk_del, prev_busy, prev_mrv;
    exp_t          e;
    pulses = 0; bcyc = 0; pvec = '0; pdata = '0; prev_addr = '0; acc_addr = '0;
    chk_del = 1'b0; prev_busy = 1'b0; prev_mrv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulses = 0; bcyc = 0; pvec = '0; chk_del = 1'b0;
        prev_busy = 1'b0; prev_mrv = 1'b0; acc_addr = '0;
        mem_q.delete();
        continue;
      end
      if (chk_del) begin
        check("deliver_hold", 64'(resp_data), 64'(pdata));
        chk_del = 1'b0;
      end
      if (req_ready != '0) begin
        pulses++;
        pvec    = req_ready;
        pdata   = resp_data;
        chk_del = 1'b1;
      end
      if (mem_rd_valid) begin
        if (prev_mrv) check("issue_addr_stable", 64'(mem_rd_addr), 64'(prev_addr));
        if (mem_rd_ready) acc_addr = mem_rd_addr;
      end
      prev_mrv  = mem_rd_valid;
      prev_addr = mem_rd_addr;
      if (busy) bcyc++;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_txn", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("mem_addr_p%0d", e.port), 64'(acc_addr), 64'(e.addr));
          check("grant_count", 64'(pulses), e.wd ? 64'(0) : 64'(1));
          check("grant_vec", 64'(pvec), e.wd ? 64'(0) : (64'(1) << e.port));
          if (!e.wd) check("resp_data", 64'(pdata), 64'(e.data));
        end
        if (mem_q.size() == 0) check("mem_timing_missing", 64'(1), 64'(0));
        else check("busy_cycles", 64'(bcyc), 64'(4 + mem_q.pop_front()));
        pulses = 0; bcyc = 0; pvec = '0;
      end
      prev_busy = busy;
    end
  end

  logic [N-1:0] dir_pat [8] = '{4'b0001, 4'b1111, 4'b1111, 4'b1111,
                                4'b0101, 4'b0101, 4'b0010, 4'b1111};
  bit           dir_wd  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    logic [N*AW-1:0] addrs;
    logic [N-1:0]    pat;
    int              r, n;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_reset");

    for (int t = 0; t < NTX; t++) begin
      addrs = {$urandom(), $urandom()};
      if (t < 8) begin
        if (t == 0) addrs[0 +: AW] = 16'h0040;
        do_txn(dir_pat[t], addrs, dir_wd[t]);
      end else begin
        r = int'($urandom_range(0, 9));
        if (r < 3) pat = '1;
        else if (r == 9) pat = '0;
        else pat = N'($urandom_range(1, (1 << N) - 1));
        do_txn(pat, addrs, ($urandom_range(0, 5) == 0));
      end
    end

    // Reset while waiting on memory; the late response must be ignored.
    stall = 1'b1;
    req_valid = 4'b0100;
    req_addr  = {$urandom(), $urandom()};
    @(negedge clk);
    check("rst_test_started", 64'(busy), 64'(1));
    n = 0;
    while (!(busy && !mem_rd_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_in_wait", 64'(busy && !mem_rd_valid), 64'(1));
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("wait_reset");
    #1 rst = 1'b0;
    req_valid = '0;
    stall = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_reset_outputs("post_reset");
    end
    last_port = N - 1;
    do_txn(4'b1111, {$urandom(), $urandom()}, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
